serial_add_arbiter: RTL and testbench

Bit-serial addition controller that time-shares a single one-bit full-adder cell between two requesters. It grants one requester at a time with round-robin priority, captures that requester's WIDTH-bit operands, and steps the cell once per clock from LSB to MSB. It then returns the registered sum and carry-out with a one-cycle done pulse to the granted requester. It sits between the game-logic blocks that need occasional additions (score, position offsets) and the shared adder cell, trading latency for area.

---
 rtl/serial_add_arbiter_pkg.sv | 21 ++
 rtl/serial_add_arbiter_if.sv | 45 ++++
 rtl/serial_add_arbiter_full_adder_cell.sv | 18 +
 rtl/serial_add_arbiter.sv | 152 +++++++++++++++
 tb/tb_serial_add_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_arbiter_pkg
//   Shared definitions for the bit-serial addition arbiter:
//     - DEF_WIDTH   : default operand/sum width
//     - state_e     : controller states (IDLE, SHIFT, DONE)
//     - REQ_0/REQ_1 : requester index constants, as carried on 'grant'
// ---------------------------------------------------------------------------
package serial_add_arbiter_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage : serial_add_arbiter_pkg

// File: rtl/serial_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// serial_add_arbiter_if
//   Bundle between the two requesters and the arbiter.
//   Requester side (master modport) drives:
//     req0/req1 : level requests, held until the matching done pulse
//     a0,b0     : requester 0 operands (sampled only at grant)
//     a1,b1     : requester 1 operands (sampled only at grant)
//   Arbiter side (slave modport) drives:
//     busy      : high whenever the arbiter is not idle
//     grant     : index of the requester being served (valid while busy)
//     done0/1   : one-cycle result-valid pulse for the matching requester
//     sum, cout : registered result, held until the next completion
//   WIDTH must match the WIDTH of the serial_add_arbiter it is bound to.
// ---------------------------------------------------------------------------
interface serial_add_arbiter_if
  import serial_add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;

  logic             busy;
  logic             grant;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  busy, grant, done0, done1, sum, cout
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output busy, grant, done0, done1, sum, cout
  );

endinterface : serial_add_arbiter_if

// File: rtl/serial_add_arbiter_full_adder_cell.sv
// ---------------------------------------------------------------------------
// full_adder_cell
//   The single shared one-bit full adder stepped by the arbiter once per
//   clock. Purely combinational.
//   Ports: a, b, cin -> s (sum bit), cout (carry out)
// ---------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder_cell

// File: rtl/serial_add_arbiter.sv
// ---------------------------------------------------------------------------
// serial_add_arbiter
//   Time-shares one full_adder_cell between two requesters. A request seen in
//   IDLE is granted (round-robin on ties), its operands are captured, and the
//   cell is stepped LSB to MSB for WIDTH cycles. A DONE cycle then registers
//   sum/cout and pulses the granted requester's done on the same edge.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : serial_add_arbiter_if.slave (requests, operands, results)
// ---------------------------------------------------------------------------
module serial_add_arbiter
  import serial_add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_add_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q,      state_d;
  logic               grant_q,      grant_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   opa_q,        opa_d;
  logic [WIDTH-1:0]   opb_q,        opb_d;
  logic [WIDTH-1:0]   acc_q,        acc_d;
  logic               carry_q,      carry_d;
  logic [CNT_W-1:0]   count_q,      count_d;
  logic [WIDTH-1:0]   sum_q,        sum_d;
  logic               cout_q,       cout_d;
  logic               done0_q,      done0_d;
  logic               done1_q,      done1_d;

  logic               pick;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic               fa_s;
  logic               fa_c;

  // On a tie, serve whoever was not served last; otherwise serve the only
  // requester present. Only meaningful in IDLE.
  assign pick  = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
  assign a_sel = (pick == REQ_1) ? bus.a1 : bus.a0;
  assign b_sel = (pick == REQ_1) ? bus.b1 : bus.b0;

  full_adder_cell u_cell (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    count_d      = count_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d = pick;
          opa_d   = a_sel;
          opb_d   = b_sel;
          carry_d = 1'b0;
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Operands drain LSB-first into the cell; sum bits enter acc at the
        // MSB so that after WIDTH steps acc holds the sum in natural order.
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_c;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        sum_d        = acc_q;
        cout_d       = carry_q;
        done0_d      = (grant_q == REQ_0);
        done1_d      = (grant_q == REQ_1);
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // and the block's statement order cannot change behaviour.
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_0;
      last_grant_q <= REQ_1;   // requester 0 wins the first tie
      opa_q        <= '0;
      opb_q        <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      count_q      <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.grant = grant_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule : serial_add_arbiter

// File: tb/tb_serial_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_add_arbiter
//   Self-checking bench for serial_add_arbiter (WIDTH = 8). Inputs change and
//   outputs are sampled on the falling edge. Expected results come from plain
//   (a + b) arithmetic; fairness is judged by how many of the other
//   requester's completions a pending request has to sit through.
// ---------------------------------------------------------------------------
module tb_serial_add_arbiter;
  import serial_add_arbiter_pkg::*;

  localparam int W       = 8;
  localparam int RND_OPS = 1000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_add_arbiter_if #(.WIDTH(W)) bus ();

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic set_req(input int idx, input logic v);
    if (idx == 0) bus.req0 = v;
    else          bus.req1 = v;
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    if (idx == 0) begin bus.a0 = a; bus.b0 = b; end
    else          begin bus.a1 = a; bus.b1 = b; end
  endtask

  // Waits (bounded) for a done pulse. Reports which requester finished, the
  // falling edges elapsed, how many of them saw busy, and grant at first busy.
  task automatic wait_done(output int who, output int cycles, output int busy_cycles,
                           output int first_grant);
    who = -1; cycles = 0; busy_cycles = 0; first_grant = -1;
    while (who < 0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (bus.busy) begin
        busy_cycles++;
        if (first_grant < 0) first_grant = int'(bus.grant);
      end
      if (bus.done0 || bus.done1) begin
        check("done_excl", 32'(bus.done0 & bus.done1), 0);
        who = bus.done1 ? 1 : 0;
      end
    end
    if (who < 0) check("done_timeout", 1, 0);
  endtask

  // Single request from an idle arbiter: full timing and result check.
  task automatic directed(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
    int who, cyc, bcyc, g;
    logic [W:0] r;
    r = ref_add(a, b);
    @(negedge clk);
    set_ops(idx, a, b);
    set_req(idx, 1'b1);
    wait_done(who, cyc, bcyc, g);
    set_req(idx, 1'b0);
    check({tag, "_who"},   who, idx);
    check({tag, "_grant"}, g, idx);
    // req sampled at the first edge, done raised WIDTH+1 edges after it
    check({tag, "_lat"},   cyc, W + 2);
    check({tag, "_busy"},  bcyc, W + 1);
    check({tag, "_sum"},   32'(bus.sum), 32'(r[W-1:0]));
    check({tag, "_cout"},  32'(bus.cout), 32'(r[W]));
    check({tag, "_idle"},  32'(bus.busy), 0);
  endtask

  initial begin
    int who, cyc, bcyc, g, seen;
    int exp_who [4];
    logic [W-1:0] exp_sum [4];

    reset    = 1'b1;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done",  32'({bus.done1, bus.done0}), 0);
    check("rst_sum",   32'(bus.sum), 0);
    check("rst_cout",  32'(bus.cout), 0);

    // Single requests
    directed(0, 8'h35, 8'h4A, "r0");
    directed(1, 8'hFF, 8'h01, "r1");

    // Simultaneous requests straight out of reset, both held: 0,1,0,1
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_who = '{0, 1, 0, 1};
    exp_sum = '{8'h30, 8'h07, 8'h30, 8'h07};
    set_ops(0, 8'h10, 8'h20);
    set_ops(1, 8'h03, 8'h04);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(who, cyc, bcyc, g);
      check($sformatf("tie%0d_who", i), who, exp_who[i]);
      check($sformatf("tie%0d_sum", i), 32'(bus.sum), 32'(exp_sum[i]));
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Operands change after grant and req drops mid-operation
    @(negedge clk);
    set_ops(0, 8'h12, 8'h34);
    bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    bus.a0 = 8'hAA;
    bus.b0 = 8'h00;
    repeat (2) @(negedge clk);
    bus.req0 = 1'b0;
    wait_done(who, cyc, bcyc, g);
    check("late_who",  who, 0);
    check("late_sum",  32'(bus.sum), 32'h46);
    check("late_cout", 32'(bus.cout), 0);

    // Reset during SHIFT (count = 4): in-flight operation discarded
    @(negedge clk);
    set_ops(1, 8'h80, 8'h90);
    bus.req1 = 1'b1;
    repeat (5) @(negedge clk);
    reset    = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_sum",   32'(bus.sum), 0);
    check("mid_rst_cout",  32'(bus.cout), 0);
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_done",  32'({bus.done1, bus.done0}), 0);
    reset = 1'b0;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) seen++;
    end
    check("mid_rst_quiet", seen, 0);
    directed(1, 8'h80, 8'h90, "post_rst");

    // Randomized traffic against the arithmetic model
    begin
      logic         pend [2];
      logic [W-1:0] ea   [2];
      logic [W-1:0] eb   [2];
      int           gap  [2];
      int           done_cnt, cycles, w;
      logic [W:0]   r;
      pend = '{1'b0, 1'b0};
      gap  = '{0, 0};
      ea   = '{'0, '0};
      eb   = '{'0, '0};
      done_cnt = 0;
      cycles   = 0;
      while (done_cnt < RND_OPS && cycles < 60000) begin
        @(negedge clk);
        cycles++;
        if (bus.done0 || bus.done1) begin
          check("rnd_excl", 32'(bus.done0 & bus.done1), 0);
          w = bus.done1 ? 1 : 0;
          r = ref_add(ea[w], eb[w]);
          check("rnd_pending", 32'(pend[w]), 1);
          check("rnd_sum",     32'(bus.sum), 32'(r[W-1:0]));
          check("rnd_cout",    32'(bus.cout), 32'(r[W]));
          check("rnd_starve",  32'(gap[w] <= 1), 1);
          pend[w] = 1'b0;
          gap[w]  = 0;
          set_req(w, 1'b0);
          if (pend[1-w]) gap[1-w]++;
          done_cnt++;
        end
        for (int i = 0; i < 2; i++) begin
          if (!pend[i] && $urandom_range(2) == 0) begin
            ea[i]   = W'($urandom);
            eb[i]   = W'($urandom);
            pend[i] = 1'b1;
            set_ops(i, ea[i], eb[i]);
            set_req(i, 1'b1);
          end
        end
      end
      check("rnd_complete", done_cnt, RND_OPS);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_add_arbiter
